ct_cp0_pmp_csr_seq: RTL and testbench

//  CP0-side sequencer driving the PMP CSR port (reg_num / wreg / wdata, read-back via pmp_cp0_data).

---
 rtl/ct_pmp_pkg.sv | 58 +++++
 rtl/ct_pmp_csr_merge.sv | 83 ++++++++
 rtl/ct_cp0_pmp_csr_seq.sv | 153 +++++++++++++++
 tb/tb_ct_cp0_pmp_csr_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_pmp_pkg.sv
// Shared definitions for the CP0 PMP CSR sequencer: op encodings, CSR
// offsets, pmpcfg bit positions, FSM states and small decode helpers.
package ct_pmp_pkg;

    // CSR instruction flavours as delivered by the issuing pipe
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    // PMP CSR offsets relative to 0x3A0
    localparam logic [4:0] CSR_CFG0      = 5'd0;
    localparam logic [4:0] CSR_CFG2      = 5'd2;
    localparam logic [4:0] CSR_ADDR_BASE = 5'd16;

    // pmpcfg byte fields
    localparam int CFG_L    = 7;
    localparam int CFG_A_HI = 4;
    localparam int CFG_A_LO = 3;
    localparam int CFG_W    = 1;
    localparam int CFG_R    = 0;
    localparam logic [1:0] CFG_A_TOR = 2'b01;

    // Number of upper pmpaddr bits that are hardwired to zero
    localparam int ADDR_ZERO_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CFG0 = 3'd1,
        ST_RD_CFG2 = 3'd2,
        ST_RD_TGT  = 3'd3,
        ST_WR      = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

    // Control fields of an accepted request
    typedef struct packed {
        logic [1:0] op;
        logic [4:0] num;
        logic       nowr;
        logic       illegal;
    } pmp_ctrl_t;

    // Only pmpcfg0, pmpcfg2 and pmpaddr0..15 exist on RV64
    function automatic logic num_legal(input logic [4:0] num);
        return (num == CSR_CFG0) || (num == CSR_CFG2) || (num >= CSR_ADDR_BASE);
    endfunction

    // Config byte of entry idx: entries 0..7 live in cfg0, 8..15 in cfg2
    function automatic logic [7:0] cfg_byte(input logic [63:0] cfg0,
                                            input logic [63:0] cfg2,
                                            input logic [3:0]  idx);
        logic [63:0] src;
        src = idx[3] ? cfg2 : cfg0;
        return src[{idx[2:0], 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ct_pmp_csr_merge.sv
// Combinational merge of old CSR value and source operand into the value
// written back to the PMP, including per-byte L locking of pmpcfg, entry
// locking (own L, TOR lock from entry i+1) of pmpaddr, and WARL clearing.
// Optional macro CT_PMP_WARL_RW_EN: a cfg byte whose new R/W is 0/1 keeps
// its old contents instead of taking the reserved combination.
module ct_pmp_csr_merge
    import ct_pmp_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int PMP_ENTRY_NUM = 16
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] src_val,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] cfg0,
    input  logic [DATA_W-1:0] cfg2,
    input  logic [4:0]        num,
    output logic [DATA_W-1:0] wdata,
    output logic              wen
);

    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] new_val;
    logic [DATA_W-1:0] cfg_wdata;
    logic [DATA_W-1:0] addr_wdata;
    logic [NBYTES-1:0] byte_open;
    logic [3:0]        idx;
    logic [7:0]        cur_cfg;
    logic [7:0]        nxt_cfg;
    logic              addr_blocked;
    logic              addr_impl;

    // CSR read-modify-write value before any locking/WARL rules
    always_comb begin
        new_val = src_val;
        case (op)
            OP_RS:   new_val = old_val | src_val;
            OP_RC:   new_val = old_val & ~src_val;
            default: new_val = src_val;
        endcase
    end

    // pmpcfg: each byte is independently lockable; bits 6:5 are reserved
    for (genvar k = 0; k < NBYTES; k++) begin : g_cfg_byte
        logic [7:0] ob;
        logic [7:0] nb;
        logic       keep;
        assign ob = old_val[8*k +: 8];
        assign nb = new_val[8*k +: 8] & 8'h9F;
`ifdef CT_PMP_WARL_RW_EN
        assign keep = ob[CFG_L] | (nb[CFG_W:CFG_R] == 2'b10);
`else
        assign keep = ob[CFG_L];
`endif
        assign cfg_wdata[8*k +: 8] = keep ? ob : nb;
        assign byte_open[k]        = ~ob[CFG_L];
    end

    // pmpaddr: entry lock check and WARL upper bits
    always_comb begin
        idx          = num[3:0];
        cur_cfg      = cfg_byte(cfg0, cfg2, idx);
        nxt_cfg      = cfg_byte(cfg0, cfg2, idx + 4'd1);
        addr_blocked = cur_cfg[CFG_L] |
                       ((idx != 4'hF) && nxt_cfg[CFG_L] &&
                        (nxt_cfg[CFG_A_HI:CFG_A_LO] == CFG_A_TOR));
        addr_impl    = int'(idx) < PMP_ENTRY_NUM;
        addr_wdata   = {{ADDR_ZERO_BITS{1'b0}}, new_val[DATA_W-ADDR_ZERO_BITS-1:0]};
    end

    // Select result by target register class
    always_comb begin
        if (num[4]) begin
            wdata = addr_wdata;
            wen   = !addr_blocked && addr_impl;
        end else begin
            wdata = cfg_wdata;
            wen   = |byte_open;
        end
    end

endmodule

// File: rtl/ct_cp0_pmp_csr_seq.sv
// CP0-side sequencer for PMP CSR accesses: one CSRRW/RS/RC becomes a
// read-then-conditional-write on the PMP register port, with the old value
// returned to the issuing pipe on a one-cycle done pulse. pmpaddr writes
// first read both cfg registers so lock rules can be applied.
// Optional macro CT_PMP_WARL_RW_EN (handled in ct_pmp_csr_merge).
module ct_cp0_pmp_csr_seq
    import ct_pmp_pkg::*;
#(
    parameter int PMP_ENTRY_NUM = 16,
    parameter int DATA_W        = 64
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              iu_pmp_req_vld,
    input  logic [1:0]        iu_pmp_req_op,
    input  logic [4:0]        iu_pmp_req_num,
    input  logic [DATA_W-1:0] iu_pmp_req_src,
    input  logic              iu_pmp_req_nowr,
    output logic              pmp_iu_req_rdy,
    output logic              pmp_iu_done,
    output logic              pmp_iu_illegal,
    output logic [DATA_W-1:0] pmp_iu_rdata,
    output logic [4:0]        cp0_pmp_reg_num,
    output logic              cp0_pmp_wreg,
    output logic [DATA_W-1:0] cp0_pmp_wdata,
    input  logic [DATA_W-1:0] pmp_cp0_data
);

    seq_state_e        state_q, state_d;
    pmp_ctrl_t         ctrl_q, ctrl_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] cfg0_q, cfg0_d;
    logic [DATA_W-1:0] cfg2_q, cfg2_d;
    logic [DATA_W-1:0] old_q, old_d;

    logic              req_acc;
    logic              req_illegal;
    logic              tgt_unimpl;
    logic [DATA_W-1:0] merge_wdata;
    logic              merge_wen;

    assign req_acc     = iu_pmp_req_vld && (state_q == ST_IDLE);
    assign req_illegal = (iu_pmp_req_op == OP_NONE) || !num_legal(iu_pmp_req_num);
    assign tgt_unimpl  = ctrl_q.num[4] && (int'(ctrl_q.num[3:0]) >= PMP_ENTRY_NUM);

    ct_pmp_csr_merge #(
        .DATA_W        (DATA_W),
        .PMP_ENTRY_NUM (PMP_ENTRY_NUM)
    ) u_merge (
        .old_val (old_q),
        .src_val (src_q),
        .op      (ctrl_q.op),
        .cfg0    (cfg0_q),
        .cfg2    (cfg2_q),
        .num     (ctrl_q.num),
        .wdata   (merge_wdata),
        .wen     (merge_wen)
    );

    // FSM state register
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Request and captured read-data registers
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            ctrl_q <= '0;
            src_q  <= '0;
            cfg0_q <= '0;
            cfg2_q <= '0;
            old_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            src_q  <= src_d;
            cfg0_q <= cfg0_d;
            cfg2_q <= cfg2_d;
            old_q  <= old_d;
        end
    end

    // Next state: only pmpaddr writes need the cfg registers for lock checks
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_acc) begin
                    if (req_illegal)
                        state_d = ST_DONE;
                    else if (iu_pmp_req_num[4] && !iu_pmp_req_nowr)
                        state_d = ST_RD_CFG0;
                    else
                        state_d = ST_RD_TGT;
                end
            end
            ST_RD_CFG0: state_d = ST_RD_CFG2;
            ST_RD_CFG2: state_d = ST_RD_TGT;
            ST_RD_TGT:  state_d = ST_WR;
            ST_WR:      state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Latch request on accept, capture PMP read data in the read states
    always_comb begin
        ctrl_d = ctrl_q;
        src_d  = src_q;
        cfg0_d = cfg0_q;
        cfg2_d = cfg2_q;
        old_d  = old_q;
        if (req_acc) begin
            ctrl_d.op      = iu_pmp_req_op;
            ctrl_d.num     = iu_pmp_req_num;
            ctrl_d.nowr    = iu_pmp_req_nowr;
            ctrl_d.illegal = req_illegal;
            src_d          = iu_pmp_req_src;
        end
        case (state_q)
            ST_RD_CFG0: cfg0_d = pmp_cp0_data;
            ST_RD_CFG2: cfg2_d = pmp_cp0_data;
            ST_RD_TGT:  old_d  = tgt_unimpl ? '0 : pmp_cp0_data;
            default: ;
        endcase
    end

    // Outputs decoded from state; reg_num stays on the target through WR
    always_comb begin
        pmp_iu_req_rdy  = (state_q == ST_IDLE);
        pmp_iu_done     = (state_q == ST_DONE);
        pmp_iu_illegal  = (state_q == ST_DONE) && ctrl_q.illegal;
        pmp_iu_rdata    = '0;
        cp0_pmp_reg_num = '0;
        cp0_pmp_wreg    = 1'b0;
        cp0_pmp_wdata   = '0;
        case (state_q)
            ST_RD_CFG0: cp0_pmp_reg_num = CSR_CFG0;
            ST_RD_CFG2: cp0_pmp_reg_num = CSR_CFG2;
            ST_RD_TGT:  cp0_pmp_reg_num = ctrl_q.num;
            ST_WR: begin
                cp0_pmp_reg_num = ctrl_q.num;
                cp0_pmp_wreg    = !ctrl_q.nowr && merge_wen;
                cp0_pmp_wdata   = merge_wdata;
            end
            ST_DONE: begin
                if (!ctrl_q.illegal) pmp_iu_rdata = old_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ct_cp0_pmp_csr_seq.sv
// Self-checking bench for ct_cp0_pmp_csr_seq. The bench owns a 32-entry
// PMP register file behind the CSR port and predicts each transaction
// (latency, write strobe, write data, old value) from the lock/WARL rules.
module tb_ct_cp0_pmp_csr_seq;

    logic        clk;
    logic        cpurst;
    logic        vld;
    logic [1:0]  op;
    logic [4:0]  num;
    logic [63:0] src;
    logic        nowr;
    logic        rdy;
    logic        done;
    logic        illegal;
    logic [63:0] rdata;
    logic [4:0]  reg_num;
    logic        wreg;
    logic [63:0] wdata;
    logic [63:0] pmp_cp0_data;

    ct_cp0_pmp_csr_seq dut (
        .forever_cpuclk  (clk),
        .cpurst          (cpurst),
        .iu_pmp_req_vld  (vld),
        .iu_pmp_req_op   (op),
        .iu_pmp_req_num  (num),
        .iu_pmp_req_src  (src),
        .iu_pmp_req_nowr (nowr),
        .pmp_iu_req_rdy  (rdy),
        .pmp_iu_done     (done),
        .pmp_iu_illegal  (illegal),
        .pmp_iu_rdata    (rdata),
        .cp0_pmp_reg_num (reg_num),
        .cp0_pmp_wreg    (wreg),
        .cp0_pmp_wdata   (wdata),
        .pmp_cp0_data    (pmp_cp0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PMP register file seen through the CSR port, plus a backdoor for setup
    logic [63:0] pmp_mem [0:31];
    logic        bd_en;
    logic [4:0]  bd_idx;
    logic [63:0] bd_val;
    assign pmp_cp0_data = pmp_mem[reg_num];
    always @(posedge clk) begin
        if (bd_en)     pmp_mem[bd_idx]  <= bd_val;
        else if (wreg) pmp_mem[reg_num] <= wdata;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Expected transaction, filled in by the stimulus
    logic        chk_on;
    logic        busy_m;
    int          acc_cyc;
    int          lat_m;
    logic        wr_m;
    logic        ill_m;
    logic        rdaddr_m;
    logic [4:0]  num_m;
    logic [63:0] wdata_m;
    logic [63:0] rdata_m;

    // Observed history used by the literal checks
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [63:0] last_wdata;
    logic [63:0] last_rdata;
    logic        last_ill;

    int   k_c;
    logic eb_c, ed_c, ew_c;

    // Cycle-by-cycle compare of the DUT against the expected transaction
    always @(negedge clk) begin
        if (!cpurst && chk_on) begin
            k_c  = cyc - acc_cyc;
            eb_c = busy_m && (k_c >= 1) && (k_c <= lat_m);
            ed_c = eb_c && (k_c == lat_m);
            ew_c = eb_c && wr_m && (k_c == lat_m - 1);
            chk("rdy", rdy, !eb_c);
            chk("done", done, ed_c);
            chk("wreg", wreg, ew_c);
            if (wreg) begin wr_cnt++; last_wdata = wdata; end
            if (done) begin done_cnt++; last_rdata = rdata; last_ill = illegal; end
            if (ew_c) begin
                chk("wdata", wdata, wdata_m);
                chk("wr_reg_num", reg_num, num_m);
            end
            if (ed_c) begin
                chk("illegal", illegal, ill_m);
                chk("rdata", rdata, rdata_m);
            end
            if (eb_c && rdaddr_m && k_c == 1) chk("rd_cfg0_num", reg_num, 64'd0);
            if (eb_c && rdaddr_m && k_c == 2) chk("rd_cfg2_num", reg_num, 64'd2);
            if (eb_c && !ill_m && k_c == lat_m - 2) chk("rd_tgt_num", reg_num, num_m);
        end
    end

    task automatic bd(input logic [4:0] i, input logic [63:0] v);
        bd_en = 1'b1; bd_idx = i; bd_val = v;
        @(posedge clk); #1;
        bd_en = 1'b0;
    endtask

    function automatic logic [7:0] ent_cfg(input int i);
        logic [63:0] r;
        r = (i < 8) ? pmp_mem[0] : pmp_mem[2];
        return 8'(r >> (8 * (i % 8)));
    endfunction

    // Predict a transaction from the architectural rules
    task automatic predict(input logic [1:0] o, input logic [4:0] n,
                           input logic [63:0] s, input logic nw);
        logic [63:0] old, nv, w;
        logic [7:0]  ob, nb, cc, cn;
        logic        any_open, blk;
        int          idx;
        ill_m    = (o == 2'b00) || !((n == 5'd0) || (n == 5'd2) || (n >= 5'd16));
        num_m    = n;
        rdaddr_m = !ill_m && (n >= 5'd16) && !nw;
        wdata_m  = 64'd0;
        if (ill_m) begin
            lat_m = 1; wr_m = 1'b0; rdata_m = 64'd0;
        end else begin
            old = pmp_mem[n];
            if (o == 2'b01)      nv = s;
            else if (o == 2'b10) nv = old | s;
            else                 nv = old & ~s;
            if (n < 5'd16) begin
                w = 64'd0; any_open = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    ob = 8'(old >> (8 * b));
                    nb = 8'(nv >> (8 * b)) & 8'h9F;
`ifdef CT_PMP_WARL_RW_EN
                    if (nb[1:0] == 2'b10) nb = ob;
`endif
                    if (ob[7]) nb = ob;
                    else       any_open = 1'b1;
                    w = w | (64'(nb) << (8 * b));
                end
                wr_m  = !nw && any_open;
                lat_m = 3;
            end else begin
                idx = int'(n) - 16;
                cc  = ent_cfg(idx);
                cn  = (idx < 15) ? ent_cfg(idx + 1) : 8'h00;
                blk = cc[7] || (cn[7] && cn[4:3] == 2'b01);
                w   = nv & 64'h003F_FFFF_FFFF_FFFF;
                wr_m  = !nw && !blk;
                lat_m = nw ? 3 : 5;
            end
            wdata_m = w;
            rdata_m = old;
        end
    endtask

    // Issue one request from idle and run it to completion; junk keeps vld
    // high with a different request while the sequencer is busy
    task automatic issue(input logic [1:0] o, input logic [4:0] n,
                         input logic [63:0] s, input logic nw, input logic junk);
        predict(o, n, s, nw);
        op = o; num = n; src = s; nowr = nw; vld = 1'b1;
        acc_cyc = cyc; busy_m = 1'b1;
        @(posedge clk); #1;
        if (junk) begin num = 5'd5; op = 2'b01; end
        else vld = 1'b0;
        repeat (lat_m - 1) @(posedge clk);
        #1 vld = 1'b0;
        @(posedge clk); #1;
        busy_m = 1'b0;
    endtask

    int w0, d0;

    initial begin
        cpurst = 1'b1; vld = 1'b0; op = 2'b00; num = 5'd0; src = 64'd0; nowr = 1'b0;
        bd_en = 1'b0; bd_idx = 5'd0; bd_val = 64'd0;
        chk_on = 1'b0; busy_m = 1'b0; acc_cyc = 0; lat_m = 1;
        wr_m = 1'b0; ill_m = 1'b0; rdaddr_m = 1'b0; num_m = 5'd0;
        wdata_m = 64'd0; rdata_m = 64'd0;
        last_wdata = 64'd0; last_rdata = 64'd0; last_ill = 1'b0;
        for (int i = 0; i < 32; i++) bd(5'(i), 64'd0);

        // Reset state
        chk("rst_rdy", rdy, 64'd1);
        chk("rst_done", done, 64'd0);
        chk("rst_illegal", illegal, 64'd0);
        chk("rst_wreg", wreg, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_reg_num", reg_num, 64'd0);
        @(posedge clk); #1 cpurst = 1'b0;
        @(posedge clk); #1 chk_on = 1'b1;

        // cfg0 RW from zero
        w0 = wr_cnt;
        issue(2'b01, 5'd0, 64'h0F1F, 1'b0, 1'b0);
        chk("t1_wr_count", wr_cnt - w0, 64'd1);
        chk("t1_wdata_lit", last_wdata, 64'h0F1F);
        chk("t1_rdata_lit", last_rdata, 64'd0);

        // cfg0 with byte1 locked
        bd(5'd0, 64'h8000);
        issue(2'b01, 5'd0, 64'hFFFF, 1'b0, 1'b0);
        chk("t2_wdata_lit", last_wdata, 64'h809F);
        chk("t2_rdata_lit", last_rdata, 64'h8000);

        // addr3 locked by TOR entry 4, addr4 locked by its own L
        bd(5'd0, 64'h0000_0089_0000_0000);
        bd(5'd19, 64'hABCD);
        w0 = wr_cnt;
        issue(2'b01, 5'd19, 64'h1234, 1'b0, 1'b0);
        chk("t3_rdata_lit", last_rdata, 64'hABCD);
        chk("t3_mem_kept", pmp_mem[19], 64'hABCD);
        issue(2'b10, 5'd20, 64'h1, 1'b0, 1'b0);
        chk("t3_no_wreg", wr_cnt - w0, 64'd0);

        // addr5 unlocked, upper bits cleared
        issue(2'b01, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        chk("t4_wdata_lit", last_wdata, 64'h003F_FFFF_FFFF_FFFF);

        // RS read-only with vld held high while busy
        bd(5'd16, 64'h5555);
        w0 = wr_cnt; d0 = done_cnt;
        issue(2'b10, 5'd16, 64'hFF, 1'b1, 1'b1);
        chk("t5_no_wreg", wr_cnt - w0, 64'd0);
        chk("t5_one_done", done_cnt - d0, 64'd1);
        chk("t5_rdata_lit", last_rdata, 64'h5555);

        // Illegal number and illegal op
        issue(2'b10, 5'd5, 64'h1, 1'b0, 1'b0);
        chk("t6_ill_lit", last_ill, 64'd1);
        chk("t6_rdata_lit", last_rdata, 64'd0);
        issue(2'b00, 5'd0, 64'h1, 1'b0, 1'b0);
        chk("t6_op_ill_lit", last_ill, 64'd1);

        // cfg2 RS
        bd(5'd2, 64'h1);
        issue(2'b10, 5'd2, 64'h100, 1'b0, 1'b0);
        chk("t7_wdata_lit", last_wdata, 64'h101);

        // addr14 TOR-locked by entry 15; addr15 has nothing above it
        bd(5'd2, 64'h8800_0000_0000_0000);
        w0 = wr_cnt;
        issue(2'b01, 5'd30, 64'h5, 1'b0, 1'b0);
        chk("t8_no_wreg", wr_cnt - w0, 64'd0);
        bd(5'd2, 64'h0800_0000_0000_0000);
        bd(5'd31, 64'hFF);
        issue(2'b11, 5'd31, 64'h0F, 1'b0, 1'b0);
        chk("t8_wdata_lit", last_wdata, 64'hF0);

        // R=0,W=1 cfg byte
        bd(5'd2, 64'd0);
        issue(2'b01, 5'd2, 64'h02, 1'b0, 1'b0);
`ifdef CT_PMP_WARL_RW_EN
        chk("t9_warl_lit", last_wdata, 64'h00);
`else
        chk("t9_warl_lit", last_wdata, 64'h02);
`endif

        // Reset pulse while in RD_CFG2
        bd(5'd0, 64'd0);
        w0 = wr_cnt; d0 = done_cnt;
        op = 2'b01; num = 5'd20; src = 64'h77; nowr = 1'b0; vld = 1'b1;
        acc_cyc = cyc; busy_m = 1'b1; lat_m = 5; wr_m = 1'b1; ill_m = 1'b0;
        rdaddr_m = 1'b1; num_m = 5'd20; wdata_m = 64'h77; rdata_m = pmp_mem[20];
        @(posedge clk); #1 vld = 1'b0;
        @(posedge clk); #1;
        chk("t10_in_rd_cfg2", reg_num, 64'd2);
        busy_m = 1'b0;
        cpurst = 1'b1;
        #1;
        chk("t10_rst_wreg", wreg, 64'd0);
        chk("t10_rst_rdy", rdy, 64'd1);
        chk("t10_rst_done", done, 64'd0);
        cpurst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t10_no_wreg", wr_cnt - w0, 64'd0);
        chk("t10_no_done", done_cnt - d0, 64'd0);

        // Recovery after reset
        issue(2'b01, 5'd0, 64'h1, 1'b0, 1'b0);
        chk("t11_wdata_lit", last_wdata, 64'h1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
